// File: rtl/keypad_if.sv
// Keypad pin and key-code bundle between the scanner and the capture logic.
interface keypad_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [1:0] key_row;
   logic [1:0] key_col;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_n,
      output col_n, key_row, key_col, key_valid, key_held
   );

   modport slave (
      output row_n,
      input  col_n, key_row, key_col, key_valid, key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with row encoder and press/release debounce.
// Debounce states exist only when KEYPAD_DEBOUNCE_EN is defined.
module keypad_scanner #(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CYCLES = 20
) (
   input logic      clk,
   input logic      rst,
   keypad_if.master kp
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

   if (SCAN_DIV < 4 || DEB_CYCLES < 1) begin : g_bad_cfg
      $error("keypad_scanner: SCAN_DIV must be >= 4, DEB_CYCLES >= 1");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    s1_q, s2_q, row_s;
   logic [PW-1:0] pre_q, pre_d;
   logic [1:0]    c_q, c_d;
   logic [1:0]    krow_q, krow_d;
   logic [1:0]    kcol_q, kcol_d;
   logic          valid_q, valid_d;
   logic          held_q, held_d;
   logic [1:0]    hit_row;
   logic          tick, any_low, all_high;

`ifdef KEYPAD_DEBOUNCE_EN
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   logic [DW-1:0] deb_q, deb_d;
   logic [1:0]    r_q, r_d;
`endif

   assign row_s    = s2_q;
   assign tick     = (pre_q == PRE_LAST);
   assign any_low  = (row_s != 4'hF);
   assign all_high = ~any_low;

   // Lowest-index low row wins when several rows read low together.
   always_comb begin
      hit_row = 2'd3;
      if (!row_s[0])      hit_row = 2'd0;
      else if (!row_s[1]) hit_row = 2'd1;
      else if (!row_s[2]) hit_row = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      c_d     = c_q;
      krow_d  = krow_q;
      kcol_d  = kcol_q;
      valid_d = 1'b0;
      held_d  = held_q;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_d   = deb_q;
      r_d     = r_q;
`endif
      case (state_q)
         SCAN: begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
               if (any_low) begin
`ifdef KEYPAD_DEBOUNCE_EN
                  r_d     = hit_row;
                  deb_d   = '0;
                  state_d = DEBOUNCE;
`else
                  krow_d  = hit_row;
                  kcol_d  = c_q;
                  valid_d = 1'b1;
                  held_d  = 1'b1;
                  state_d = PRESSED;
`endif
               end else begin
                  c_d = c_q + 2'd1;
               end
            end
         end
`ifdef KEYPAD_DEBOUNCE_EN
         DEBOUNCE: begin
            if (!row_s[r_q]) begin
               if (deb_q == DEB_LAST) begin
                  krow_d  = r_q;
                  kcol_d  = c_q;
                  valid_d = 1'b1;
                  held_d  = 1'b1;
                  deb_d   = '0;
                  state_d = PRESSED;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               deb_d   = '0;
               state_d = SCAN;
            end
         end
         PRESSED: begin
            if (all_high) begin
               deb_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (all_high) begin
               if (deb_q == DEB_LAST) begin
                  held_d  = 1'b0;
                  c_d     = c_q + 2'd1;
                  deb_d   = '0;
                  state_d = SCAN;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               deb_d   = '0;
               state_d = PRESSED;
            end
         end
`else
         PRESSED: begin
            if (all_high) begin
               held_d  = 1'b0;
               c_d     = c_q + 2'd1;
               state_d = SCAN;
            end
         end
`endif
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 4'hF;
         s2_q    <= 4'hF;
         state_q <= SCAN;
         pre_q   <= '0;
         c_q     <= 2'd0;
         krow_q  <= 2'd0;
         kcol_q  <= 2'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
         deb_q   <= '0;
         r_q     <= 2'd0;
`endif
      end else begin
         s1_q    <= kp.row_n;
         s2_q    <= s1_q;
         state_q <= state_d;
         pre_q   <= pre_d;
         c_q     <= c_d;
         krow_q  <= krow_d;
         kcol_q  <= kcol_d;
         valid_q <= valid_d;
         held_q  <= held_d;
`ifdef KEYPAD_DEBOUNCE_EN
         deb_q   <= deb_d;
         r_q     <= r_d;
`endif
      end
   end

   assign kp.col_n     = ~(4'b0001 << c_q);
   assign kp.key_row   = krow_q;
   assign kp.key_col   = kcol_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=8, DEB_CYCLES=4).
// Expected latencies follow KEYPAD_DEBOUNCE_EN.
module tb_keypad_scanner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_if kif ();

   keypad_scanner #(.SCAN_DIV(8), .DEB_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kif)
   );

`ifdef KEYPAD_DEBOUNCE_EN
   localparam int LAT = 5;
   localparam int REL = 5;
`else
   localparam int LAT = 1;
   localparam int REL = 1;
`endif

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] c;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   // Keys pressed in the matrix, indexed [row][col].
   logic [3:0][3:0] press = '0;

   always_comb begin
      for (int r = 0; r < 4; r++)
         kif.row_n[r] = ~|(press[r] & ~kif.col_n);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst && kif.key_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: cyc=%0d row=%0d col=%0d",
                     cyc, kif.key_row, kif.key_col);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (kif.key_row !== e.r || kif.key_col !== e.c || cyc != e.cyc) begin
               errors++;
               $display("FAIL key_valid: got r=%0d c=%0d cyc=%0d expected r=%0d c=%0d cyc=%0d",
                        kif.key_row, kif.key_col, cyc, e.r, e.c, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: cyc=%0d got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push(input logic [1:0] r, input logic [1:0] c, input int t);
      exp_t e;
      e.r = r;
      e.c = c;
      e.cyc = t;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and free-running column scan.
      @(negedge clk);
      chk("rst_col_n", kif.col_n, 4'b1110);
      chk("rst_key_row", {2'b0, kif.key_row}, 4'd0);
      chk("rst_key_col", {2'b0, kif.key_col}, 4'd0);
      chk("rst_flags", {2'b0, kif.key_valid, kif.key_held}, 4'd0);
      do_reset();
      wait_cyc(7);  chk("scan_c0_end", kif.col_n, 4'b1110);
      wait_cyc(8);  chk("scan_c1", kif.col_n, 4'b1101);
      wait_cyc(16); chk("scan_c2", kif.col_n, 4'b1011);
      wait_cyc(24); chk("scan_c3", kif.col_n, 4'b0111);
      wait_cyc(32); chk("scan_wrap", kif.col_n, 4'b1110);

      // Steady key row 2 / col 1, then release.
      press = '0;
      press[2][1] = 1'b1;
      push(2'd2, 2'd1, 15 + LAT);
      do_reset();
      wait_cyc(30);
      chk("held_21", {3'b0, kif.key_held}, 4'd1);
      wait_cyc(40);
      press = '0;
      wait_cyc(41 + REL);
      chk("held_before_rel", {3'b0, kif.key_held}, 4'd1);
      wait_cyc(42 + REL);
      chk("held_after_rel", {3'b0, kif.key_held}, 4'd0);
      chk("col_after_rel", kif.col_n, 4'b1011);
      chk("key_row_hold", {2'b0, kif.key_row}, 4'd2);
      wait_cyc(49 + REL);
      chk("col2_dwell", kif.col_n, 4'b1011);
      wait_cyc(50 + REL);
      chk("col3_after", kif.col_n, 4'b0111);

      // Two-cycle bounce on row 2 around the column-1 tick.
      press = '0;
      do_reset();
      wait_cyc(13);
      press[2][1] = 1'b1;
`ifndef KEYPAD_DEBOUNCE_EN
      push(2'd2, 2'd1, 16);
`endif
      wait_cyc(15);
      press = '0;
      wait_cyc(18);
`ifdef KEYPAD_DEBOUNCE_EN
      chk("bounce_col_hold", kif.col_n, 4'b1101);
      wait_cyc(25);
      chk("bounce_col_end", kif.col_n, 4'b1101);
      wait_cyc(26);
      chk("bounce_col_next", kif.col_n, 4'b1011);
      chk("bounce_held", {3'b0, kif.key_held}, 4'd0);
`else
      chk("bounce_col_next", kif.col_n, 4'b1011);
      chk("bounce_held", {3'b0, kif.key_held}, 4'd0);
`endif

      // Rows 1 and 3 together in column 0: row 1 wins.
      press = '0;
      press[1][0] = 1'b1;
      press[3][0] = 1'b1;
      push(2'd1, 2'd0, 7 + LAT);
      do_reset();
      wait_cyc(20);
      chk("multi_held", {3'b0, kif.key_held}, 4'd1);
      chk("multi_col", kif.col_n, 4'b1110);

      // Reset while PRESSED.
      press = '0;
      press[2][1] = 1'b1;
      push(2'd2, 2'd1, 15 + LAT);
      do_reset();
      wait_cyc(25);
      chk("pre_rst_held", {3'b0, kif.key_held}, 4'd1);
      rst = 1'b1;
      #1;
      chk("midrst_col", kif.col_n, 4'b1110);
      chk("midrst_flags", {2'b0, kif.key_valid, kif.key_held}, 4'd0);
      chk("midrst_key", {kif.key_row, kif.key_col}, 4'd0);
      press = '0;
      do_reset();
      wait_cyc(7);
      chk("restart_c0", kif.col_n, 4'b1110);
      wait_cyc(8);
      chk("restart_c1", kif.col_n, 4'b1101);

      // Key row 0 / col 3 with column wrap after release.
      press = '0;
      press[0][3] = 1'b1;
      push(2'd0, 2'd3, 31 + LAT);
      do_reset();
      wait_cyc(40);
      press = '0;
      wait_cyc(41 + REL);
      chk("held03_before", {3'b0, kif.key_held}, 4'd1);
      wait_cyc(42 + REL);
      chk("held03_after", {3'b0, kif.key_held}, 4'd0);
      chk("col_wrap_rel", kif.col_n, 4'b1110);
      chk("key03_hold", {kif.key_row, kif.key_col}, 4'b0011);

      repeat (10) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_valid: %0d expected strobes never seen", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
